// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared FIR op codes and stream-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4,
        OUT     = 3'd5
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_ctrl
// Description : Streams a frame into the FIR filter, runs it, streams results out.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int SIGNAL_LENGTH = 1000,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              fir_reset,
    output logic [1:0]        fir_op,
    output logic [ADDR_W-1:0] fir_addr,
    output logic [DATA_W-1:0] fir_x,
    input  logic [DATA_W-1:0] fir_y,
    input  logic              fir_done
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(SIGNAL_LENGTH - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Result register: loaded from the filter's registered read data in CAPTURE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (r_state == CAPTURE) begin
            m_valid <= 1'b1;
            m_data  <= fir_y;
            m_last  <= (r_cnt == c_LAST);
        end else if (r_state == OUT && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        s_ready     = 1'b0;
        fir_op      = OP_IDLE;
        fir_x       = '0;
        case (r_state)
            CLEAR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                fir_x   = s_data;
                if (s_valid) begin
                    fir_op = OP_WRITE;
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (fir_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = READ;
                end else begin
                    fir_op = OP_RUN;
                end
            end
            READ: begin
                fir_op      = OP_READ;
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    if (m_last) begin
                        w_state_nxt = CLEAR;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = READ;
                    end
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // The filter is held in reset for the whole time the block itself is
    assign fir_reset = ~reset | (r_state == CLEAR);
    assign fir_addr  = r_cnt;
    assign busy      = (r_state != LOAD);

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_stream_ctrl
// Description : Directed bench for fir_stream_ctrl with a behavioural 4-tap FIR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;
    import fir_pkg::*;

    localparam int N = 8;
    localparam int COEF[4] = '{1, 2, 3, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        fir_reset;
    logic [1:0]  fir_op;
    logic [31:0] fir_addr;
    logic [31:0] fir_x;
    logic [31:0] fir_y;
    logic        fir_done;

    fir_stream_ctrl #(.SIGNAL_LENGTH(N), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .fir_reset(fir_reset), .fir_op(fir_op), .fir_addr(fir_addr),
        .fir_x(fir_x), .fir_y(fir_y), .fir_done(fir_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_last = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Behavioural filter: sync active-high reset, sticky done, registered read data
    logic [31:0] fx[N];
    logic        r_done;
    int          run_cnt;
    int          run_delay;
    logic        done_early;

    function automatic logic [31:0] conv(input int n);
        logic [31:0] acc;
        acc = 0;
        for (int k = 0; k < 4; k++)
            if (n - k >= 0) acc = acc + 32'(COEF[k]) * fx[n-k];
        return acc;
    endfunction

    always @(posedge clk) begin
        if (fir_reset) begin
            for (int i = 0; i < N; i++) fx[i] <= 0;
            r_done  <= 1'b0;
            run_cnt <= 0;
            fir_y   <= 0;
        end else begin
            case (fir_op)
                OP_WRITE: fx[fir_addr[2:0]] <= fir_x;
                OP_RUN: if (!r_done) begin
                    if (run_cnt == run_delay) r_done <= 1'b1;
                    else run_cnt <= run_cnt + 1;
                end
                OP_READ: fir_y <= conv(int'(fir_addr[2:0]));
                default: ;
            endcase
        end
    end
    assign fir_done = r_done | done_early;

    // Protocol monitor on the filter side
    int run_ops = 0;
    int rd_idx  = 0;
    always @(negedge clk) begin
        if (fir_reset) begin
            run_ops = 0;
            rd_idx  = 0;
        end else begin
            if (fir_op == OP_RUN) begin
                run_ops++;
                chk("run_while_done", fir_done, 1'b0);
            end
            if (fir_op == OP_READ) begin
                chk("read_addr", fir_addr, rd_idx);
                rd_idx++;
            end
        end
    end

    typedef struct {
        logic [31:0] din[N];
        logic [31:0] dout[N];
        int          gap;
        int          bp;
        int          rdly;
        bit          early;
    } vec_t;
    vec_t vecs[5];

    task automatic send(input logic [31:0] d[N], input int n, input int gap);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(99) < gap) begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end else begin
                s_valid = 1'b1;
                s_data  = d[i];
            end
            #1;
            chk("s_ready_load", s_ready, 1'b1);
            chk("busy_load", busy, 1'b0);
            chk("fir_op_load", fir_op, s_valid ? OP_WRITE : OP_IDLE);
            if (s_valid) begin
                chk("wr_addr", fir_addr, i);
                chk("fir_x", fir_x, d[i]);
            end
            @(posedge clk);
            #1;
            if (s_valid) begin
                i++;
                t_last = cyc;
            end
        end
        if (i < n) timeout("send");
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
    endtask

    task automatic recv(input logic [31:0] e[N], input int bp, input int exp_lat);
        int k = 0;
        int guard = 0;
        bit stalled = 1'b0;
        bit first = 1'b1;
        logic [31:0] pd = 0;
        logic pl = 1'b0;
        while (k < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            m_ready = ($urandom_range(99) >= bp);
            #1;
            chk("busy_out", busy, 1'b1);
            chk("s_ready_out", s_ready, 1'b0);
            if (stalled) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, pd);
                chk("hold_last", m_last, pl);
            end
            if (m_valid) begin
                if (first) begin
                    chk("latency", cyc - t_last, exp_lat);
                    first = 1'b0;
                end
                if (m_ready) begin
                    chk("m_data", m_data, e[k]);
                    chk("m_last", m_last, k == N - 1);
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = m_data;
                    pl = m_last;
                end
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk);
        end
        if (k < N) timeout("recv");
    endtask

    task automatic frame_end(input int exp_run_ops);
        #1;
        chk("read_count", rd_idx, N);
        chk("run_ops", run_ops, exp_run_ops);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        chk("clear_fir_reset", fir_reset, 1'b1);
        chk("clear_m_valid", m_valid, 1'b0);
        chk("clear_busy", busy, 1'b1);
        @(negedge clk);
        #1;
        chk("rearm_fir_reset", fir_reset, 1'b0);
        chk("rearm_s_ready", s_ready, 1'b1);
    endtask

    initial begin
        vecs[0] = '{din: '{1, 0, 0, 0, 0, 0, 0, 0},  dout: '{1, 2, 3, 4, 0, 0, 0, 0},
                    gap: 0,  bp: 0,  rdly: 2, early: 1'b0};
        vecs[1] = '{din: '{1, 1, 1, 1, 1, 1, 1, 1},  dout: '{1, 3, 6, 10, 10, 10, 10, 10},
                    gap: 0,  bp: 0,  rdly: 0, early: 1'b0};
        vecs[2] = '{din: '{1, 1, 1, 1, 1, 1, 1, 1},  dout: '{1, 3, 6, 10, 10, 10, 10, 10},
                    gap: 50, bp: 50, rdly: 3, early: 1'b0};
        vecs[3] = '{din: '{1, 2, 3, 4, 5, 6, 7, 8},  dout: '{1, 4, 10, 20, 30, 40, 50, 60},
                    gap: 0,  bp: 0,  rdly: 5, early: 1'b1};
        vecs[4] = '{din: '{5, 0, 0, 0, 0, 0, 0, 2},  dout: '{5, 10, 15, 20, 0, 0, 0, 2},
                    gap: 30, bp: 30, rdly: 1, early: 1'b0};

        reset = 1'b0;
        s_valid = 1'b0;
        s_data = 0;
        m_ready = 1'b0;
        run_delay = 2;
        done_early = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_fir_reset", fir_reset, 1'b1);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("clear_after_rst", fir_reset, 1'b1);
        @(negedge clk);
        #1;
        chk("load_after_rst", s_ready, 1'b1);
        chk("load_fir_reset", fir_reset, 1'b0);

        // Back-to-back frames with varying run time, gaps and backpressure
        for (int v = 0; v < 5; v++) begin
            run_delay  = vecs[v].rdly;
            done_early = vecs[v].early;
            send(vecs[v].din, N, vecs[v].gap);
            recv(vecs[v].dout, vecs[v].bp, vecs[v].early ? 3 : vecs[v].rdly + 4);
            frame_end(vecs[v].early ? 0 : vecs[v].rdly + 1);
            done_early = 1'b0;
        end

        // Reset mid-frame, then a clean ones frame
        run_delay = 1;
        send(vecs[1].din, 5, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("midrst_m_valid", m_valid, 1'b0);
            chk("midrst_fir_reset", fir_reset, 1'b1);
            chk("midrst_s_ready", s_ready, 1'b0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_rearm", s_ready, 1'b1);
        send(vecs[1].din, N, 0);
        recv(vecs[1].dout, 0, 5);
        frame_end(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
